wb_unit: RTL and testbench
==========================

WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, GPR index width.
REQ-002 Parameter DATA_WIDTH, default 64, GPR data width.
REQ-003 clk  in  1  sole clock, all state updates on posedge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 exu_valid/exu_wen/exu_rd/exu_data  in  1/1/ADDR_WIDTH/DATA_WIDTH  EXU result offer.
REQ-006 exu_ready  out  1  EXU result accepted this cycle when high with exu_valid.
REQ-007 lsu_valid/lsu_wen/lsu_rd/lsu_data  in  1/1/ADDR_WIDTH/DATA_WIDTH  LSU (load) result offer.
REQ-008 lsu_ready  out  1  LSU result accepted this cycle when high with lsu_valid.
REQ-009 wb_hold  in  1  freeze writeback; no pop while high.
REQ-010 issue_valid/issue_rd  in  1/ADDR_WIDTH  issue of an instruction that will write issue_rd.
REQ-011 q_rs1/q_rs2/q_rd  in  ADDR_WIDTH each  scoreboard query indices.
REQ-012 rs1_busy/rs2_busy/rd_busy  out  1 each  pending-write status of queried index.
REQ-013 rf_wen/rf_waddr/rf_wdata  out  1/ADDR_WIDTH/DATA_WIDTH  GPR file write port.
REQ-014 wb_count  out  32  number of GPR writes performed since reset.

Function
REQ-015 Block SHALL hold a 2-entry in-order FIFO of {wen, rd, data}; count 0..2.
REQ-016 At most one push per cycle; LSU has fixed priority over EXU.
REQ-017 lsu_ready = !rst && count_eff<2; exu_ready = !rst && count_eff<2 && !lsu_valid; count_eff = count minus one if a pop occurs this cycle.
REQ-018 Push occurs on (x_valid && x_ready); payload captured at that posedge.
REQ-019 Pop occurs in any cycle with count>0 && !wb_hold; head entry drives the write port combinationally that cycle.
REQ-020 rf_wen = pop && head.wen && head.rd!=0; rf_waddr/rf_wdata = head fields when count>0, else 0.
REQ-021 Latency: result accepted in cycle N appears on rf_* in cycle N+1 if FIFO was empty and wb_hold low; written to GPR at end of N+1.
REQ-022 Simultaneous push and pop with count=2 SHALL be permitted (REQ-017); count unchanged.
REQ-023 Scoreboard: busy[1..2^ADDR_WIDTH-1], registered; index 0 never busy.
REQ-024 Set busy[issue_rd] on issue_valid && issue_rd!=0.
REQ-025 Clear busy[rf_waddr] when rf_wen is high.
REQ-026 Same-cycle set and clear of one index: set wins (busy stays 1).
REQ-027 Entries with wen=0 or rd=0 SHALL NOT clear any busy bit.
REQ-028 x_busy = busy[q_x] from registered state; a same-cycle clear is not bypassed; q_x=0 gives 0.
REQ-029 Issue logic guarantees at most one outstanding writer per rd (checks rd_busy); block need not count multiple writers.
REQ-030 wb_count increments by 1 on each cycle rf_wen is high; wraps 0xFFFFFFFF -> 0.
REQ-031 Valid with ready low: offering source holds payload; block SHALL NOT drop or duplicate.

Reset
REQ-032 On rst high at posedge: count=0, FIFO pointers 0, all busy=0, wb_count=0.
REQ-033 While rst high: exu_ready=0, lsu_ready=0, rf_wen=0; no push, no pop, no busy set.
REQ-034 Reset mid-operation SHALL discard buffered entries without issuing rf writes.
REQ-035 After rst falls, first cycle: rf_waddr=0, rf_wdata=0, all busy outputs 0, both readys 1 (exu_ready 1 only if lsu_valid=0).

Verification
REQ-036 issue_valid rd=5; next cycle EXU valid rd=5 data=0x1234 -> rd_busy(q_rd=5)=1, accept, next cycle rf_wen=1 waddr=5 wdata=0x1234, following cycle busy cleared, wb_count=1.
REQ-037 EXU and LSU valid same cycle (rd=3, rd=4) -> LSU accepted first, exu_ready=0; writes order rd=4 then rd=3 on consecutive cycles.
REQ-038 wb_hold=1, push 3 results -> third offer sees ready=0, rf_wen=0; release hold -> two writes in consecutive cycles, third accepted in the same cycle as first pop, no loss.
REQ-039 Result rd=0 data=0xFFFF and wen=0 rd=7 -> rf_wen stays 0 for both, wb_count unchanged, busy[7] unaffected.
REQ-040 Issue rd=9 in same cycle rf_wen writes rd=9 -> busy[9]=1 next cycle.
REQ-041 Fill FIFO with wb_hold=1, assert rst one cycle -> no rf_wen ever, count=0, all busy 0, readys 1 after reset.

Source files
------------

// File: rtl/wb_unit.sv
// wb_unit -- writeback unit with a 2-entry result FIFO and a GPR scoreboard.
//
// Purpose:
//   Accepts results from the LSU and the EXU, with the LSU taking fixed
//   priority. Results are queued in order in a 2-entry FIFO and drained to
//   the GPR write port one per cycle unless wb_hold is high. A pending-write
//   scoreboard tracks destination registers from issue until writeback.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   exu_valid/wen/rd/data, exu_ready  EXU result offer and handshake
//   lsu_valid/wen/rd/data, lsu_ready  LSU result offer and handshake
//   wb_hold                           freezes draining of the FIFO
//   issue_valid, issue_rd             marks issue_rd as pending a write
//   q_rs1/q_rs2/q_rd                  scoreboard query indices
//   rs1_busy/rs2_busy/rd_busy         pending status of the queried indices
//   rf_wen, rf_waddr, rf_wdata        GPR file write port
//   wb_count                          GPR writes performed since reset
module wb_unit #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  exu_valid,
   input  logic                  exu_wen,
   input  logic [ADDR_WIDTH-1:0] exu_rd,
   input  logic [DATA_WIDTH-1:0] exu_data,
   output logic                  exu_ready,
   input  logic                  lsu_valid,
   input  logic                  lsu_wen,
   input  logic [ADDR_WIDTH-1:0] lsu_rd,
   input  logic [DATA_WIDTH-1:0] lsu_data,
   output logic                  lsu_ready,
   input  logic                  wb_hold,
   input  logic                  issue_valid,
   input  logic [ADDR_WIDTH-1:0] issue_rd,
   input  logic [ADDR_WIDTH-1:0] q_rs1,
   input  logic [ADDR_WIDTH-1:0] q_rs2,
   input  logic [ADDR_WIDTH-1:0] q_rd,
   output logic                  rs1_busy,
   output logic                  rs2_busy,
   output logic                  rd_busy,
   output logic                  rf_wen,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata,
   output logic [31:0]           wb_count
);

   localparam int NREG = 1 << ADDR_WIDTH;

   logic                  mem_wen_r  [2];
   logic [ADDR_WIDTH-1:0] mem_rd_r   [2];
   logic [DATA_WIDTH-1:0] mem_data_r [2];
   logic                  wr_ptr_r;
   logic                  rd_ptr_r;
   logic [1:0]            count_r;
   logic [NREG-1:0]       busy_r;
   logic [31:0]           wb_count_r;

   logic                  pop_s;
   logic [1:0]            count_eff_s;
   logic                  space_s;
   logic                  push_s;
   logic                  push_wen_s;
   logic [ADDR_WIDTH-1:0] push_rd_s;
   logic [DATA_WIDTH-1:0] push_data_s;
   logic [NREG-1:0]       busy_nxt_s;

   // Pop / free-space evaluation; a pop in this cycle frees a slot for a push.
   always_comb begin
      pop_s       = !rst && (count_r != 2'd0) && !wb_hold;
      count_eff_s = count_r - {1'b0, pop_s};
      space_s     = !rst && (count_eff_s < 2'd2);
   end

   assign lsu_ready = space_s;
   assign exu_ready = space_s && !lsu_valid;

   // Push source selection: LSU has fixed priority over EXU.
   always_comb begin
      push_s      = 1'b0;
      push_wen_s  = 1'b0;
      push_rd_s   = '0;
      push_data_s = '0;
      if (lsu_valid && lsu_ready) begin
         push_s      = 1'b1;
         push_wen_s  = lsu_wen;
         push_rd_s   = lsu_rd;
         push_data_s = lsu_data;
      end else if (exu_valid && exu_ready) begin
         push_s      = 1'b1;
         push_wen_s  = exu_wen;
         push_rd_s   = exu_rd;
         push_data_s = exu_data;
      end else begin
         push_s      = 1'b0;
      end
   end

   // Head of the FIFO drives the GPR write port combinationally.
   always_comb begin
      rf_wen = pop_s && mem_wen_r[rd_ptr_r] && (mem_rd_r[rd_ptr_r] != '0);
      if (count_r != 2'd0) begin
         rf_waddr = mem_rd_r[rd_ptr_r];
         rf_wdata = mem_data_r[rd_ptr_r];
      end else begin
         rf_waddr = '0;
         rf_wdata = '0;
      end
   end

   // FIFO payload storage; contents are only observed while count_r is nonzero.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_wen_r[wr_ptr_r]  <= push_wen_s;
         mem_rd_r[wr_ptr_r]   <= push_rd_s;
         mem_data_r[wr_ptr_r] <= push_data_s;
      end
   end

   // FIFO pointers and occupancy; reset discards any buffered entries.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         count_r <= count_r + {1'b0, push_s} - {1'b0, pop_s};
      end
   end

   // Scoreboard next state: an issue set beats a same-cycle writeback clear.
   always_comb begin
      busy_nxt_s = '0;
      for (int i = 1; i < NREG; i++) begin
         busy_nxt_s[i] = (issue_valid && (issue_rd == ADDR_WIDTH'(i))) ||
                         (busy_r[i] && !(rf_wen && (rf_waddr == ADDR_WIDTH'(i))));
      end
      busy_nxt_s[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r <= '0;
      end else begin
         busy_r <= busy_nxt_s;
      end
   end

   // Writeback counter, wraps naturally at 32 bits.
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_count_r <= 32'd0;
      end else if (rf_wen) begin
         wb_count_r <= wb_count_r + 32'd1;
      end
   end

   assign rs1_busy = busy_r[q_rs1];
   assign rs2_busy = busy_r[q_rs2];
   assign rd_busy  = busy_r[q_rd];
   assign wb_count = wb_count_r;

endmodule

// File: tb/tb_wb_unit.sv
// tb_wb_unit -- directed self-checking bench for wb_unit.
// A queue-based model of the writeback unit is checked against the DUT every
// cycle on the falling edge; directed scenarios add literal expectations.
module tb_wb_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        exu_valid, exu_wen, lsu_valid, lsu_wen;
   logic [4:0]  exu_rd, lsu_rd, issue_rd, q_rs1, q_rs2, q_rd;
   logic [63:0] exu_data, lsu_data;
   logic        exu_ready, lsu_ready, wb_hold, issue_valid;
   logic        rs1_busy, rs2_busy, rd_busy, rf_wen;
   logic [4:0]  rf_waddr;
   logic [63:0] rf_wdata;
   logic [31:0] wb_count;

   int errors = 0;
   int checks = 0;

   wb_unit #(.ADDR_WIDTH(5), .DATA_WIDTH(64)) dut (
      .clk(clk), .rst(rst),
      .exu_valid(exu_valid), .exu_wen(exu_wen), .exu_rd(exu_rd),
      .exu_data(exu_data), .exu_ready(exu_ready),
      .lsu_valid(lsu_valid), .lsu_wen(lsu_wen), .lsu_rd(lsu_rd),
      .lsu_data(lsu_data), .lsu_ready(lsu_ready),
      .wb_hold(wb_hold), .issue_valid(issue_valid), .issue_rd(issue_rd),
      .q_rs1(q_rs1), .q_rs2(q_rs2), .q_rd(q_rd),
      .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .rd_busy(rd_busy),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .wb_count(wb_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct packed {
      logic        wen;
      logic [4:0]  rd;
      logic [63:0] data;
   } ent_t;

   ent_t        mq[$];
   bit          mbusy[32];
   int unsigned mcnt;
   bit          m_pop, m_space, m_wr;
   ent_t        m_head;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_lsu_ready", lsu_ready, 1'b0);
         chk("rst_exu_ready", exu_ready, 1'b0);
         chk("rst_rf_wen", rf_wen, 1'b0);
         mq.delete();
         foreach (mbusy[i]) mbusy[i] = 1'b0;
         mcnt = 0;
      end else begin
         m_pop   = (mq.size() > 0) && !wb_hold;
         m_space = (mq.size() - (m_pop ? 1 : 0)) < 2;
         m_head  = (mq.size() > 0) ? mq[0] : '0;
         m_wr    = m_pop && m_head.wen && (m_head.rd != 5'd0);
         chk("cyc_rf_wen", rf_wen, m_wr);
         chk("cyc_rf_waddr", rf_waddr, m_head.rd);
         chk("cyc_rf_wdata", rf_wdata, m_head.data);
         chk("cyc_lsu_ready", lsu_ready, m_space);
         chk("cyc_exu_ready", exu_ready, m_space && !lsu_valid);
         chk("cyc_rs1_busy", rs1_busy, mbusy[q_rs1]);
         chk("cyc_rs2_busy", rs2_busy, mbusy[q_rs2]);
         chk("cyc_rd_busy", rd_busy, mbusy[q_rd]);
         chk("cyc_wb_count", wb_count, mcnt);
         // state effects of the coming rising edge
         if (m_pop) void'(mq.pop_front());
         if (m_wr) begin
            mbusy[m_head.rd] = 1'b0;
            mcnt = mcnt + 1;
         end
         if (issue_valid && issue_rd != 5'd0) mbusy[issue_rd] = 1'b1;
         if (lsu_valid && m_space) mq.push_back({lsu_wen, lsu_rd, lsu_data});
         else if (exu_valid && m_space) mq.push_back({exu_wen, exu_rd, exu_data});
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      exu_valid = 1'b0; exu_wen = 1'b0; exu_rd = 5'd0; exu_data = 64'd0;
      lsu_valid = 1'b0; lsu_wen = 1'b0; lsu_rd = 5'd0; lsu_data = 64'd0;
      issue_valid = 1'b0; issue_rd = 5'd0;
   endtask

   task automatic exu(input logic [4:0] rd, input logic [63:0] d);
      exu_valid = 1'b1; exu_wen = 1'b1; exu_rd = rd; exu_data = d;
   endtask

   task automatic lsu(input logic w, input logic [4:0] rd, input logic [63:0] d);
      lsu_valid = 1'b1; lsu_wen = w; lsu_rd = rd; lsu_data = d;
   endtask

   initial begin
      rst = 1'b1; wb_hold = 1'b0;
      q_rs1 = 5'd0; q_rs2 = 5'd0; q_rd = 5'd0;
      idle();
      tick(); tick();
      rst = 1'b0;
      #1;
      chk("post_rst_exu_ready", exu_ready, 1'b1);
      chk("post_rst_lsu_ready", lsu_ready, 1'b1);
      chk("post_rst_waddr", rf_waddr, 5'd0);
      chk("post_rst_count", wb_count, 32'd0);

      // basic issue -> result -> writeback, busy clear
      tick(); issue_valid = 1'b1; issue_rd = 5'd5; q_rd = 5'd5;
      tick(); idle(); exu(5'd5, 64'h1234); #1;
      chk("basic_rd_busy", rd_busy, 1'b1);
      chk("basic_exu_ready", exu_ready, 1'b1);
      tick(); idle(); #1;
      chk("basic_rf_wen", rf_wen, 1'b1);
      chk("basic_waddr", rf_waddr, 5'd5);
      chk("basic_wdata", rf_wdata, 64'h1234);
      tick(); #1;
      chk("basic_busy_clr", rd_busy, 1'b0);
      chk("basic_count", wb_count, 32'd1);

      // LSU priority over EXU
      tick(); lsu(1'b1, 5'd4, 64'h44); exu(5'd3, 64'h33); #1;
      chk("prio_exu_ready", exu_ready, 1'b0);
      chk("prio_lsu_ready", lsu_ready, 1'b1);
      tick(); lsu_valid = 1'b0; #1;
      chk("prio_first_waddr", rf_waddr, 5'd4);
      chk("prio_first_wen", rf_wen, 1'b1);
      tick(); idle(); #1;
      chk("prio_second_waddr", rf_waddr, 5'd3);
      chk("prio_second_wen", rf_wen, 1'b1);

      // hold: fill, third offer stalls, release drains in order
      tick(); wb_hold = 1'b1; exu(5'd10, 64'hA);
      tick(); exu(5'd11, 64'hB);
      tick(); exu(5'd12, 64'hC); #1;
      chk("hold_full_ready", exu_ready, 1'b0);
      chk("hold_rf_wen", rf_wen, 1'b0);
      tick(); wb_hold = 1'b0; #1;
      chk("hold_rel_wen", rf_wen, 1'b1);
      chk("hold_rel_waddr", rf_waddr, 5'd10);
      chk("hold_third_accept", exu_ready, 1'b1);
      tick(); idle(); #1;
      chk("hold_second_waddr", rf_waddr, 5'd11);
      tick(); #1;
      chk("hold_third_waddr", rf_waddr, 5'd12);
      chk("hold_third_wdata", rf_wdata, 64'hC);
      tick(); #1;
      chk("hold_drained_wen", rf_wen, 1'b0);
      chk("hold_count", wb_count, 32'd6);

      // rd=0 and wen=0 results never write or clear busy
      tick(); issue_valid = 1'b1; issue_rd = 5'd7; q_rd = 5'd7;
      tick(); idle(); lsu(1'b1, 5'd0, 64'hFFFF);
      tick(); lsu(1'b0, 5'd7, 64'h77); #1;
      chk("nowr_rd0_wen", rf_wen, 1'b0);
      tick(); idle(); #1;
      chk("nowr_wen0_wen", rf_wen, 1'b0);
      chk("nowr_wen0_waddr", rf_waddr, 5'd7);
      tick(); #1;
      chk("nowr_busy7", rd_busy, 1'b1);
      chk("nowr_count", wb_count, 32'd6);

      // issue and writeback of the same rd in one cycle: set wins
      tick(); issue_valid = 1'b1; issue_rd = 5'd9; q_rs1 = 5'd9;
      tick(); idle(); exu(5'd9, 64'h99);
      tick(); idle(); issue_valid = 1'b1; issue_rd = 5'd9; #1;
      chk("setwin_wen", rf_wen, 1'b1);
      chk("setwin_waddr", rf_waddr, 5'd9);
      tick(); idle(); #1;
      chk("setwin_busy9", rs1_busy, 1'b1);
      chk("setwin_count", wb_count, 32'd7);

      // reset with a full FIFO discards entries
      tick(); wb_hold = 1'b1; lsu(1'b1, 5'd20, 64'h1); issue_valid = 1'b1;
      issue_rd = 5'd22; q_rs2 = 5'd22;
      tick(); idle(); lsu(1'b1, 5'd21, 64'h2); #1;
      chk("rstmid_busy22", rs2_busy, 1'b1);
      tick(); idle(); rst = 1'b1; #1;
      chk("rstmid_wen", rf_wen, 1'b0);
      chk("rstmid_ready", lsu_ready, 1'b0);
      tick(); rst = 1'b0; wb_hold = 1'b0; #1;
      chk("rstmid_after_wen", rf_wen, 1'b0);
      chk("rstmid_after_waddr", rf_waddr, 5'd0);
      chk("rstmid_after_lsu_ready", lsu_ready, 1'b1);
      chk("rstmid_after_exu_ready", exu_ready, 1'b1);
      chk("rstmid_busy22_clr", rs2_busy, 1'b0);
      chk("rstmid_busy9_clr", rs1_busy, 1'b0);
      chk("rstmid_busy7_clr", rd_busy, 1'b0);
      chk("rstmid_count", wb_count, 32'd0);
      tick(); #1;
      chk("rstmid_later_wen", rf_wen, 1'b0);
      tick(); tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
